// File: rtl/dff_pipeline_bank.sv
// WIDTH x DEPTH register pipeline with per-stage valid, stall, synchronous flush and occupancy count.
// Define DFF_PIPE_TAPS_EN to expose every stage's data on the taps port.
module dff_pipeline_bank #(
  parameter int              WIDTH       = 8,
  parameter int              DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         async_reset_n,
  input  logic                         en,
  input  logic                         sync_clear,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DFF_PIPE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0]       taps
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_p   [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_nxt [DEPTH];
  logic [DEPTH-1:0] vld_nxt;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OCC_W'(v[i]);
    return c;
  endfunction

  // Invalid stages are loaded with RESET_VALUE so a bubble never carries stale data.
  always_comb begin
    data_nxt = data_p;
    vld_nxt  = vld_p;
    if (sync_clear) begin
      for (int i = 0; i < DEPTH; i++) data_nxt[i] = RESET_VALUE;
      vld_nxt = '0;
    end else if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        data_nxt[i] = data_p[i-1];
        vld_nxt[i]  = vld_p[i-1];
      end
      data_nxt[0] = d_valid ? d : RESET_VALUE;
      vld_nxt[0]  = d_valid;
    end
  end

  // Stage registers; occupancy is computed from the next valid vector so it tracks the same edge.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_VALUE;
      vld_p     <= '0;
      occupancy <= '0;
    end else begin
      data_p    <= data_nxt;
      vld_p     <= vld_nxt;
      occupancy <= popcount(vld_nxt);
    end
  end

  assign q       = data_p[DEPTH-1];
  assign q_valid = vld_p[DEPTH-1];

`ifdef DFF_PIPE_TAPS_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[WIDTH*g +: WIDTH] = data_p[g];
  end
`endif

endmodule

// File: tb/tb_dff_pipeline_bank.sv
// Bench for dff_pipeline_bank (WIDTH=8, DEPTH=4): directed scenarios plus random traffic against a queue model.
module tb_dff_pipeline_bank;

  localparam int W = 8;
  localparam int D = 4;

  logic         sim_clk;
  logic         async_reset_n;
  logic         en;
  logic         sync_clear;
  logic [W-1:0] d;
  logic         d_valid;
  logic [W-1:0] q;
  logic         q_valid;
  logic [2:0]   occupancy;
`ifdef DFF_PIPE_TAPS_EN
  logic [W*D-1:0] taps;
`endif

  dff_pipeline_bank #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(8'h00)) dut (
    .clk(sim_clk),
    .async_reset_n(async_reset_n),
    .en(en),
    .sync_clear(sync_clear),
    .d(d),
    .d_valid(d_valid),
    .q(q),
    .q_valid(q_valid),
    .occupancy(occupancy)
`ifdef DFF_PIPE_TAPS_EN
    ,
    .taps(taps)
`endif
  );

  initial sim_clk = 1'b0;
  always #20 sim_clk = ~sim_clk;

  typedef struct {
    logic         v;
    logic [W-1:0] dat;
  } ent_t;

  ent_t mdl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl.delete();
    for (int i = 0; i < D; i++) mdl.push_back('{v: 1'b0, dat: 8'h00});
  endtask

  // Model stage i is mdl[i]; an advance pushes the new word in at stage 0 and drops the last stage.
  task automatic mdl_edge(input logic e, input logic clr, input logic dv, input logic [W-1:0] dd);
    if (clr) mdl_reset();
    else if (e) begin
      mdl.push_front('{v: dv, dat: (dv ? dd : 8'h00)});
      void'(mdl.pop_back());
    end
  endtask

  function automatic int mdl_occ();
    int c = 0;
    foreach (mdl[i]) if (mdl[i].v) c++;
    return c;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(mdl[D-1].dat));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(mdl[D-1].v));
    chk({tag, ".occ"}, 32'(occupancy), 32'(mdl_occ()));
`ifdef DFF_PIPE_TAPS_EN
    chk({tag, ".taps"}, 32'(taps), {mdl[3].dat, mdl[2].dat, mdl[1].dat, mdl[0].dat});
`endif
  endtask

  // Drive inputs away from the edge, take one edge, then compare 1 ns later.
  task automatic step(input logic e, input logic clr, input logic dv, input logic [W-1:0] dd,
                      input string tag);
    en = e; sync_clear = clr; d_valid = dv; d = dd;
    @(posedge sim_clk);
    mdl_edge(e, clr, dv, dd);
    #1;
    check_all(tag);
  endtask

  logic [W-1:0] fill_q [5];

  initial begin
    fill_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    async_reset_n = 1'b0;
    en = 1'b0; sync_clear = 1'b0; d_valid = 1'b0; d = '0;
    mdl_reset();
    #5;
    chk("por.q", 32'(q), 32'h00);
    chk("por.q_valid", 32'(q_valid), 32'h0);
    chk("por.occ", 32'(occupancy), 32'h0);
    #25 async_reset_n = 1'b1;

    // Fill and drain
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, fill_q[i], "fill");
      if (i == 3) begin
        chk("fill.q_at_edge4", 32'(q), 32'h11);
        chk("fill.qv_at_edge4", 32'(q_valid), 32'h1);
`ifdef DFF_PIPE_TAPS_EN
        chk("taps.full", 32'(taps), 32'h11223344);
`endif
      end
      chk("fill.occ_count", 32'(occupancy), (i < 4) ? 32'(i + 1) : 32'd4);
      if (i == 4) chk("fill.q_edge5", 32'(q), 32'h22);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'hFF, "drain");
    chk("drain.occ_zero", 32'(occupancy), 32'h0);
    chk("drain.q_bubble", 32'(q), 32'h00);

    // Stall after two words
    step(1'b0, 1'b1, 1'b0, 8'h00, "stall.clr");
    step(1'b1, 1'b0, 1'b1, 8'h11, "stall.e1");
    step(1'b1, 1'b0, 1'b1, 8'h22, "stall.e2");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'hEE, "stall.hold");
      chk("stall.occ_hold", 32'(occupancy), 32'd2);
      chk("stall.qv_hold", 32'(q_valid), 32'h0);
    end
    step(1'b1, 1'b0, 1'b1, 8'h33, "stall.e6");
    chk("stall.qv_e6", 32'(q_valid), 32'h0);
    step(1'b1, 1'b0, 1'b1, 8'h44, "stall.e7");
    chk("stall.q_e7", 32'(q), 32'h11);
    chk("stall.qv_e7", 32'(q_valid), 32'h1);

    // Bubble in the middle of a burst
    step(1'b0, 1'b1, 1'b0, 8'h00, "bub.clr");
    step(1'b1, 1'b0, 1'b1, 8'h11, "bub.a");
    step(1'b1, 1'b0, 1'b0, 8'hFF, "bub.b");
    step(1'b1, 1'b0, 1'b1, 8'h33, "bub.c");
    step(1'b1, 1'b0, 1'b0, 8'h00, "bub.d");
    chk("bub.q1", 32'(q), 32'h11);
    step(1'b1, 1'b0, 1'b0, 8'h00, "bub.e");
    chk("bub.q2", 32'(q), 32'h00);
    chk("bub.qv2", 32'(q_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, "bub.f");
    chk("bub.q3", 32'(q), 32'h33);
    chk("bub.qv3", 32'(q_valid), 32'h1);

    // Clear beats a held pipeline and a valid input
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), "clr.fill");
    step(1'b0, 1'b1, 1'b1, 8'h77, "clr.edge");
    chk("clr.q", 32'(q), 32'h00);
    chk("clr.occ", 32'(occupancy), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, "clr.no77");

    // Async reset mid-cycle with pipeline full of AA, inputs ignored while asserted
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'hAA, "ar.fill");
    chk("ar.pre_q", 32'(q), 32'hAA);
    @(posedge sim_clk);
    #13 async_reset_n = 1'b0;
    en = 1'b1; d_valid = 1'b1; d = 8'h55;
    #1;
    mdl_reset();
    chk("ar.q", 32'(q), 32'h00);
    chk("ar.q_valid", 32'(q_valid), 32'h0);
    chk("ar.occ", 32'(occupancy), 32'h0);
    @(posedge sim_clk);
    #1;
    check_all("ar.held");
    #10 async_reset_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic re, rc, rv;
      logic [W-1:0] rd;
      re = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      rv = $urandom_range(0, 1) == 1;
      rd = 8'($urandom);
      step(re, rc, rv, rd, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
